// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state encodings and defaults for the UART frame controller
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    localparam int         FRAME_BYTES            = 8;
    localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'hFF;
    localparam int         TIMEOUT_CYCLES_DEFAULT = 200000;

endpackage

// File: rtl/uart_frame_timer.sv
// rtl/uart_frame_timer.sv - inter-byte gap timer for the UART frame controller
//
// Ports:
//   clk, resetn : clock, async active-low reset
//   clear       : restart the gap count (a byte arrived, or not in a timed state)
//   enable      : count while high
//   expired     : TIMEOUT_CYCLES consecutive enabled, uncleared cycles have elapsed
module uart_frame_timer
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the gap cycle that completes the count, so the controller leaves at that edge.
    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - sync-preamble framer assembling 8-byte payloads from a UART byte stream
//
// Optional feature macro: FRAME_CHECKSUM_EN (9th byte must equal XOR of the payload).
//
// Ports:
//   clk, resetn            : clock, async active-low reset
//   rx_valid/rx_data       : received byte strobe and value
//   rx_break               : BREAK strobe, aborts any frame not yet held
//   frame_data/frame_valid : assembled payload, held until frame_ready
//   frame_ready            : consumer accepts payload
//   byte_cnt               : payload bytes captured in current frame
//   fsm_state              : current state encoding
//   overrun/timeout/chk_err: one-cycle event pulses
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         SYNC_COUNT     = 4,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_break,
    output logic [63:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [3:0]  byte_cnt,
    output logic [2:0]  fsm_state,
    output logic        overrun,
    output logic        timeout,
    output logic        chk_err
);

    localparam logic [3:0] SYNC_LAST  = 4'(SYNC_COUNT);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BYTES);

    state_e      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  sync_q, sync_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic        chk_q, chk_d;
`endif

    logic timed, expired, is_sync, xfer, idle_eval;

    assign timed     = (state_q == ST_SYNC) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign is_sync   = (rx_data == SYNC_BYTE);
    assign xfer      = (state_q == ST_HOLD) && frame_ready;
    // A byte arriving alongside the hand-off is treated as if we were already idle.
    assign idle_eval = (state_q == ST_IDLE) || xfer;

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (rx_valid || !timed),
        .enable (timed),
        .expired(expired)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        sync_d    = sync_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d    = csum_q;
        chk_d     = 1'b0;
`endif
        if (rx_break && (state_q != ST_HOLD)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sync_d  = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (xfer) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (rx_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (expired) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else if (rx_valid) begin
                        if (!is_sync) begin
                            state_d = ST_IDLE;
                        end else if (sync_q + 4'd1 == SYNC_LAST) begin
                            state_d = ST_PAYLOAD;
                            cnt_d   = '0;
`ifdef FRAME_CHECKSUM_EN
                            csum_d  = '0;
`endif
                        end else begin
                            sync_d = sync_q + 4'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (expired) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else if (rx_valid) begin
                        data_d = {data_q[55:0], rx_data};
                        if (cnt_q != FRAME_LAST) begin
                            cnt_d = cnt_q + 4'd1;
                        end
`ifdef FRAME_CHECKSUM_EN
                        csum_d = csum_q ^ rx_data;
                        if (cnt_q == FRAME_LAST - 4'd1) begin
                            state_d = ST_CHECK;
                        end
`else
                        if (cnt_q == FRAME_LAST - 4'd1) begin
                            state_d = ST_HOLD;
                        end
`endif
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                ST_CHECK: begin
                    if (expired) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_IDLE;
                            chk_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
`endif
                default: ;
            endcase

            if (idle_eval && rx_valid && is_sync) begin
                if (SYNC_COUNT == 1) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end else begin
                    state_d = ST_SYNC;
                    sync_d  = 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            sync_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= '0;
            chk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= csum_d;
            chk_q     <= chk_d;
`endif
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = (state_q == ST_HOLD);
    assign byte_cnt    = cnt_q;
    assign fsm_state   = state_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
`ifdef FRAME_CHECKSUM_EN
    assign chk_err     = chk_q;
`else
    assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - scoreboard testbench for uart_frame_ctrl
module tb_uart_frame_ctrl;

    localparam int TMO = 64;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_break = 1'b0;
    logic        frame_ready = 1'b0;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic [3:0]  byte_cnt;
    logic [2:0]  fsm_state;
    logic        overrun, timeout, chk_err;

    int vectors = 0;
    int miscompares = 0;
    int n_overrun = 0, n_timeout = 0, n_chkerr = 0, n_valid_cycles = 0;
    int ready_mode = 1;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    uart_frame_ctrl #(
        .SYNC_BYTE(8'hFF),
        .SYNC_COUNT(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .byte_cnt(byte_cnt), .fsm_state(fsm_state),
        .overrun(overrun), .timeout(timeout), .chk_err(chk_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every handshake, tally event pulses.
    always @(negedge clk) begin
        if (resetn) begin
            if (overrun) n_overrun++;
            if (timeout) n_timeout++;
            if (chk_err) n_chkerr++;
            if (frame_valid) n_valid_cycles++;
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected none", frame_data);
                end else begin
                    check("frame_data", frame_data, exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       frame_ready = 1'b0;
            1:       frame_ready = 1'b1;
            default: frame_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference: scan the byte stream for SYNC_COUNT consecutive 0xFF, then take the next 8 bytes
    // (and, with checksum enabled, accept only if the following byte is their XOR).
    function automatic void model_push(input byte_q_t s);
        int run = 0;
        int i = 0;
        logic [63:0] f;
        logic [7:0]  x;
        while (i < s.size()) begin
            run = (s[i] == 8'hFF) ? run + 1 : 0;
            i++;
            if (run == 4) begin
                run = 0;
                if (i + 8 <= s.size()) begin
                    f = '0;
                    x = '0;
                    for (int k = 0; k < 8; k++) begin
                        f = {f[55:0], s[i + k]};
                        x = x ^ s[i + k];
                    end
                    i += 8;
`ifdef FRAME_CHECKSUM_EN
                    if (i < s.size() && s[i] == x) exp_q.push_back(f);
                    i++;
`else
                    exp_q.push_back(f);
`endif
                end else begin
                    i = s.size();
                end
            end
        end
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic send_stream(input byte_q_t s, input int maxgap);
        foreach (s[i]) send(s[i], $urandom_range(0, maxgap));
    endtask

    function automatic byte_q_t frame_bytes(input logic [63:0] p, input logic [7:0] ck);
        byte_q_t s;
        s = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int k = 7; k >= 0; k--) s.push_back(p[k*8 +: 8]);
`ifdef FRAME_CHECKSUM_EN
        s.push_back(ck);
`else
        if (ck == 8'h5A) s.push_back(ck);
`endif
        return s;
    endfunction

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        byte_q_t s;
        int o0, v0, cyc, c0;
        logic [63:0] p;
        logic [7:0]  x;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 64'(fsm_state), 64'd0);
        check("rst_data", frame_data, 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_cnt", 64'(byte_cnt), 64'd0);
        check("rst_pulses", {61'd0, overrun, timeout, chk_err}, 64'd0);
        resetn = 1'b1;

        // Basic frame, ready held high: valid lasts exactly one cycle
        ready_mode = 1;
        v0 = n_valid_cycles;
        send(8'hFF, 0); send(8'hFF, 0);
        check("sync_state", 64'(fsm_state), 64'd1);
        send(8'hFF, 0); send(8'hFF, 0);
        check("payload_state", 64'(fsm_state), 64'd2);
        check("payload_cnt0", 64'(byte_cnt), 64'd0);
        exp_q.push_back(64'h0102030405060708);
        for (int k = 1; k <= 8; k++) begin
            send(8'(k), 0);
            if (k == 3) check("payload_cnt3", 64'(byte_cnt), 64'd3);
        end
`ifdef FRAME_CHECKSUM_EN
        send(8'h08, 0);
`endif
        wait_drain("basic");
        check("valid_one_cycle", 64'(n_valid_cycles - v0), 64'd1);

        // Aborted sync run followed by a good one
        s = '{8'hFF, 8'hFF, 8'h3C};
        s = {s, frame_bytes(64'hFFA1B2C3D4E5F607, 8'hFF ^ 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4 ^ 8'hE5 ^ 8'hF6 ^ 8'h07)};
        model_push(s);
        check("abort_model_one_frame", 64'(exp_q.size()), 64'd1);
        send_stream(s, 2);
        wait_drain("abort");

        // Hold with ready low: two dropped bytes pulse overrun, data stays put
        ready_mode = 0;
        p = 64'h1122334455667788;
        x = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88;
        s = frame_bytes(p, x);
        model_push(s);
        send_stream(s, 1);
        c0 = 0;
        while (!frame_valid && c0 < 50) begin @(posedge clk); #1; c0++; end
        check("hold_state", 64'(fsm_state), 64'd4);
        o0 = n_overrun;
        send(8'hAA, 0);
        send(8'hFF, 3);
        check("overrun_pulses", 64'(n_overrun - o0), 64'd2);
        check("hold_data_stable", frame_data, p);
        check("hold_valid", 64'(frame_valid), 64'd1);
        ready_mode = 1;
        wait_drain("hold");
        check("post_hold_idle", 64'(fsm_state), 64'd0);

        // Gap timeout after 3 payload bytes
        o0 = n_timeout;
        for (int k = 0; k < 4; k++) send(8'hFF, 0);
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
        check("tmo_cnt3", 64'(byte_cnt), 64'd3);
        cyc = 0;
        while (!timeout && cyc < TMO + 20) begin @(posedge clk); #1; cyc++; end
        check("tmo_latency", 64'(cyc), 64'(TMO));
        check("tmo_state", 64'(fsm_state), 64'd0);
        check("tmo_cnt", 64'(byte_cnt), 64'd0);
        repeat (2) @(posedge clk);
        check("tmo_pulses", 64'(n_timeout - o0), 64'd1);

        // BREAK mid-frame
        for (int k = 0; k < 4; k++) send(8'hFF, 0);
        send(8'h42, 0); send(8'h43, 0);
        @(posedge clk); #1 rx_break = 1'b1;
        @(posedge clk); #1 rx_break = 1'b0;
        check("brk_state", 64'(fsm_state), 64'd0);
        check("brk_cnt", 64'(byte_cnt), 64'd0);

        // Async reset after 5 payload bytes
        for (int k = 0; k < 4; k++) send(8'hFF, 0);
        for (int k = 0; k < 5; k++) send(8'(8'h90 + k), 0);
        check("pre_rst_cnt", 64'(byte_cnt), 64'd5);
        #2 resetn = 1'b0;
        #1;
        check("midrst_state", 64'(fsm_state), 64'd0);
        check("midrst_cnt", 64'(byte_cnt), 64'd0);
        check("midrst_data", frame_data, 64'd0);
        check("midrst_valid", 64'(frame_valid), 64'd0);
        @(posedge clk); #1 resetn = 1'b1;
        p = 64'hCAFEBABE01234567;
        x = 8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE ^ 8'h01 ^ 8'h23 ^ 8'h45 ^ 8'h67;
        s = frame_bytes(p, x);
        model_push(s);
        send_stream(s, 1);
        wait_drain("after_reset");

`ifdef FRAME_CHECKSUM_EN
        // Checksum mismatch: no frame, chk_err pulse
        o0 = n_chkerr;
        s = frame_bytes(64'h0102030405060708, 8'h09);
        model_push(s);
        check("ck_model_none", 64'(exp_q.size()), 64'd0);
        send_stream(s, 0);
        repeat (2) @(posedge clk); #1;
        check("ck_err_pulse", 64'(n_chkerr - o0), 64'd1);
        check("ck_state", 64'(fsm_state), 64'd0);
`endif

        // Randomized episodes: noise with short FF runs, then a frame; ready toggles randomly
        ready_mode = 2;
        for (int e = 0; e < 12; e++) begin
            s = {};
            for (int g = $urandom_range(0, 4); g > 0; g--) begin
                for (int r = $urandom_range(0, 3); r > 0; r--) s.push_back(8'hFF);
                s.push_back(8'($urandom_range(0, 254)));
            end
            p = {$urandom, $urandom};
            if (e % 3 == 0) p[63:56] = 8'hFF;
            x = '0;
            for (int k = 0; k < 8; k++) x = x ^ p[k*8 +: 8];
            s = {s, frame_bytes(p, x)};
            model_push(s);
            send_stream(s, 5);
            wait_drain("random");
        end
        ready_mode = 1;

        repeat (5) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_overrun_total", 64'(n_overrun), 64'd2);
        check("final_timeout_total", 64'(n_timeout), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
